hazard_fwd_ctrl: RTL
====================

Name: hazard_fwd_ctrl

Overview:
- Control end of the datapath operand muxes. Tracks the destination registers in flight in EX, MEM and WB.
- Drives the 2-bit select codes of the EX-stage operand mux3 instances.
- Raises load-use stalls and inserts bubbles.
- Flushes IF/ID and ID/EX on a taken branch or jump redirect from EX.

Parameters:
- REG_AW, 5: register index width.
- NREGS, 32: architectural register count; x0 is hard-wired zero.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs1  input  REG_AW  ID source 1 index.
- id_rs2  input  REG_AW  ID source 2 index.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  REG_AW  ID destination index.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- ex_redirect  input  1  EX resolved a taken branch or jump this cycle.
- fwd_a_sel  output  2  EX operand A mux3 select: 00 regfile, 01 WB result, 10 MEM ALU result.
- fwd_b_sel  output  2  EX operand B mux3 select; same encoding.
- stall_if  output  1  hold PC.
- stall_id  output  1  hold IF/ID register.
- flush_id  output  1  clear IF/ID register.
- flush_ex  output  1  load a bubble into ID/EX.

Behaviour:
- Shadow pipeline, updated on every rising clk edge:
  - EX slot captures {valid, rs1, rs2, use flags, rd, reg_write, mem_read} from ID, or a bubble when flush_ex=1.
  - MEM slot captures the EX slot.
  - WB slot captures the MEM slot.
  - A bubble has valid=0 and reg_write=0.
- Reset (rstn=0, asynchronous):
  - All slots become bubbles.
  - All outputs are 0; fwd_*_sel=00.
  - Reset may assert mid-stall; the next cycle after release behaves as an empty pipeline.
- Forwarding (combinational from slots, zero latency), per operand X in {rs1, rs2} of the EX slot:
  - Output 10 if MEM.valid, MEM.reg_write, MEM.rd != 0, MEM.rd == X and the use flag is set.
  - Else 01 if the same conditions hold for WB.
  - Else 00.
  - MEM has priority over WB when both match.
  - X == 0 always yields 00.
  - A matching MEM slot that is a load never selects 10; load-use stalling guarantees this cannot occur.
- Load-use hazard (lu), combinational:
  - Asserted when EX.valid & EX.mem_read & EX.rd != 0 & id_valid & ((id_use_rs1 & id_rs1 == EX.rd) | (id_use_rs2 & id_rs2 == EX.rd)).
  - lu=1 drives stall_if=1, stall_id=1 and flush_ex=1 for exactly one cycle.
  - The next cycle forwards the value from WB (01).
- Redirect:
  - ex_redirect=1 drives flush_id=1 and flush_ex=1.
  - stall_if=0 and stall_id=0 so the PC can load the target.
  - Redirect overrides lu in the same cycle, because the ID instruction is squashed.
- Stall-state FSM {RUN, LU_STALL}:
  - RUN goes to LU_STALL on lu & !ex_redirect.
  - LU_STALL always returns to RUN.
  - lu cannot re-assert in LU_STALL because EX now holds a bubble. The bench asserts this with an assertion.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined: forwarding as specified above.
- Undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - A RAW hazard stalls ID, using the same outputs as lu, while any valid writing slot among EX or MEM matches a used ID source.
  - WB needs no stall because the regfile is write-first.
  - Stall lasts up to 2 cycles; the FSM gains a RAW_STALL state that exits when the match clears.
  - Redirect priority is unchanged.

Decomposition:
- Package hazard_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The stall-state enum.
  - The slot struct type {valid, rs1, rs2, use1, use2, rd, reg_write, mem_read}.
  - BUBBLE constant.
- Sub-module fwd_sel_unit: computes one operand's select from (src, use, MEM slot, WB slot); instantiated twice.

Test Plan:
- ALU chain: add x5 in ID, next add using rs1=x5 -> one cycle later fwd_a_sel=10; no stall.
- Distance-2 use of x5, with a MEM match on x6 unrelated -> fwd_b_sel=01 when rs2=x5.
- Load-use: lw x7 in EX, ID uses rs2=x7 -> stall_if=stall_id=flush_ex=1 for 1 cycle, then fwd_b_sel=01.
- x0 destination: writer rd=0 followed by a reader of x0 -> selects stay 00, no stall.
- Redirect during a load-use condition -> flush_id=flush_ex=1, stall_if=0; EX is a bubble next cycle.
- Reset asserted during LU_STALL -> all outputs 0 immediately; after release, the first dependent pair forwards correctly.
- Build without HAZARD_FWD_EN -> an ALU distance-1 dependence stalls 2 cycles and selects stay 00.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding control block.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   FWD_REG / FWD_WB / FWD_MEM - operand mux3 select codes
//   stall_state_t              - stall-state FSM encoding
//   slot_t / BUBBLE            - one shadow-pipeline slot and its empty value
//   slot_writes()              - "this slot will write register idx" predicate
package hazard_pkg;

  // Register index width carried in a shadow slot; the top-level REG_AW
  // parameter is expected to match it.
  localparam int SLOT_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_STALL  = 2'd1,
    RAW_STALL = 2'd2
  } stall_state_t;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rs1;
    logic [SLOT_AW-1:0] rs2;
    logic               use1;
    logic               use2;
    logic [SLOT_AW-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  // True when slot s holds a live instruction that will write architectural
  // register idx. x0 never counts, and indices beyond the register file
  // (reduced-register builds) never count either.
  function automatic logic slot_writes(input slot_t s,
                                       input logic [SLOT_AW-1:0] idx,
                                       input int nregs);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == idx) &&
           (int'(s.rd) < nregs);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Operand forwarding select for one EX-stage source operand.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the current slots.
//
// Ports:
//   src, use_src       - EX-stage source index and its "is read" flag
//   mem_slot, wb_slot  - shadow MEM and WB slots
//   sel                - mux3 select: FWD_MEM beats FWD_WB beats FWD_REG
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic [SLOT_AW-1:0] src,
  input  logic               use_src,
  input  slot_t              mem_slot,
  input  slot_t              wb_slot,
  output logic [1:0]         sel
);

  logic mem_hit;
  logic wb_hit;

  // A load sitting in MEM has no result on the ALU bus yet, so it is never a
  // forwarding source; the load-use stall keeps a dependent out of EX then.
  assign mem_hit = use_src && slot_writes(mem_slot, src, NREGS) && !mem_slot.mem_read;
  assign wb_hit  = use_src && slot_writes(wb_slot, src, NREGS);

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    sel = FWD_REG;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

  logic unused_fields;
  assign unused_fields = ^{mem_slot.rs1, mem_slot.rs2, mem_slot.use1, mem_slot.use2,
                           wb_slot.rs1, wb_slot.rs2, wb_slot.use1, wb_slot.use2,
                           wb_slot.mem_read};

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Latency: stall/flush/select outputs are combinational from the current
//          shadow slots and ID inputs; the shadow pipeline advances each clk.
// Backpressure: raises stall_if/stall_id (hold PC and IF/ID) and flush_ex
//          (bubble into ID/EX) on a hazard; a redirect flushes IF/ID and
//          ID/EX and always overrides a stall.
//
// Build option: HAZARD_FWD_EN
//   defined   - EX operands forwarded from MEM/WB; only load-use stalls.
//   undefined - no forwarding (selects tied to 00); any RAW dependence on a
//               writer in EX or MEM stalls ID until the writer reaches WB.
//
// Ports:
//   clk, rstn                      - clock, async active-low reset
//   id_valid .. id_mem_read        - decoded ID-stage instruction
//   ex_redirect                    - taken branch/jump resolved in EX
//   fwd_a_sel, fwd_b_sel           - EX operand mux3 selects
//   stall_if, stall_id             - hold PC / hold IF/ID
//   flush_id, flush_ex             - clear IF/ID / bubble into ID/EX
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_redirect,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              flush_ex
);

  slot_t        id_slot;
  slot_t        ex_q;
  slot_t        mem_q;
  slot_t        wb_q;
  stall_state_t state;

  logic lu;
  logic hazard;
  logic redirect;

  // ID instruction as it would enter EX. Side-effect flags are qualified
  // with valid so an empty ID slot always looks like a bubble downstream.
  always_comb begin
    id_slot           = BUBBLE;
    id_slot.valid     = id_valid;
    id_slot.rs1       = id_rs1;
    id_slot.rs2       = id_rs2;
    id_slot.use1      = id_use_rs1;
    id_slot.use2      = id_use_rs2;
    id_slot.rd        = id_rd;
    id_slot.reg_write = id_valid & id_reg_write;
    id_slot.mem_read  = id_valid & id_mem_read;
  end

  // Load in EX whose data a used ID source needs next cycle.
  assign lu = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
              ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
               (id_use_rs2 && (id_rs2 == ex_q.rd)));

`ifdef HAZARD_FWD_EN

  localparam stall_state_t HAZ_STATE = LU_STALL;

  fwd_sel_unit #(.NREGS(NREGS)) u_fwd_a (
    .src      (ex_q.rs1),
    .use_src  (ex_q.use1),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (fwd_a_sel)
  );

  fwd_sel_unit #(.NREGS(NREGS)) u_fwd_b (
    .src      (ex_q.rs2),
    .use_src  (ex_q.use2),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (fwd_b_sel)
  );

  assign hazard = lu;

  logic unused_ex;
  assign unused_ex = ex_q.reg_write;

`else

  localparam stall_state_t HAZ_STATE = RAW_STALL;

  logic raw;

  // Without forwarding every used source must wait until its producer has
  // reached WB; the register file is write-first, so WB itself is safe.
  assign raw = id_valid &&
               ((id_use_rs1 && (slot_writes(ex_q,  id_rs1, NREGS) ||
                                slot_writes(mem_q, id_rs1, NREGS))) ||
                (id_use_rs2 && (slot_writes(ex_q,  id_rs2, NREGS) ||
                                slot_writes(mem_q, id_rs2, NREGS))));

  assign fwd_a_sel = FWD_REG;
  assign fwd_b_sel = FWD_REG;

  // A load-use case is always also a RAW case; lu is kept for clarity.
  assign hazard = raw | lu;

  logic unused_slots;
  assign unused_slots = ^{wb_q, ex_q.rs1, ex_q.rs2, ex_q.use1, ex_q.use2,
                          mem_q.rs1, mem_q.rs2, mem_q.use1, mem_q.use2};

`endif

  // Gated with rstn so every control output reads 0 while reset is held,
  // even if the branch unit is still presenting a redirect.
  assign redirect = rstn & ex_redirect;

  // Redirect squashes the ID instruction, so its hazard is moot and the PC
  // must be free to load the target.
  assign stall_if = hazard & ~redirect;
  assign stall_id = hazard & ~redirect;
  assign flush_id = redirect;
  assign flush_ex = redirect | hazard;

  // Shadow pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= flush_ex ? BUBBLE : id_slot;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Stall-state tracker. A load-use stall lasts exactly one cycle (EX holds
  // a bubble afterwards); a RAW stall lasts until the producer leaves MEM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (hazard && !ex_redirect) state <= HAZ_STATE;
        end
        LU_STALL: begin
          state <= RUN;
        end
        RAW_STALL: begin
          if (!hazard || ex_redirect) state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
